sha256_round_engine: RTL
========================

Name: sha256_round_engine

Overview:
SHA-256 compression engine that consumes the round-constant lookup. It accepts one 512-bit padded message block plus a 256-bit input hash state. It runs 64 rounds at one round per clock and drives a 6-bit constant index to the external combinational K lookup. It adds the result back into the input state and presents the 256-bit digest with a one-cycle done pulse. It sits between the block-padding front end and the K constant table.

Parameters:
NUM_ROUNDS, 64, round count; fixed by the standard and not to be overridden in production.
IDX_W, 6, width of the constant index; must satisfy 2**IDX_W >= NUM_ROUNDS.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while ready=1
block_in  input  512  padded block; word W0 = bits [511:480], big-endian word order
hash_in  input  256  input state H0..H7; H0 = bits [255:224]
k_index  output  6  round constant index presented to the K lookup
k_in  input  32  constant K[k_index], combinational return in the same cycle
ready  output  1  high in IDLE only
busy  output  1  high in ROUND and FINAL
done  output  1  one-cycle pulse when hash_out is updated
hash_out  output  256  digest; holds until the next done

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, round counter=0, working registers a..h=0, W window=0.
  - hash_out=0, done=0, ready=1, busy=0, k_index=0.
  - Reset asserted mid-operation aborts the block immediately; no partial digest is produced.
- States: IDLE -> ROUND -> FINAL -> IDLE.
- IDLE:
  - ready=1.
  - start=1 at edge E0: latch hash_in into H regs and into a..h, load the 16-word W window from block_in, set round=0, go to ROUND.
- ROUND:
  - k_index=round, otherwise k_index=0.
  - Round t is computed from a..h, window word W_t and k_in.
  - T1 = h + Sigma1(e) + Ch(e,f,g) + k_in + W_t; T2 = Sigma0(a) + Maj(a,b,c); all additions mod 2^32.
  - Update at each edge: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - Window shift: W_t is consumed from the window head.
  - Word appended to the tail: sigma1(W_{t+14}) + W_{t+9} + sigma0(W_{t+1}) + W_t (i.e. W_{t+16}), computed every round; words appended for t>=48 are never consumed.
  - Rounds update at edges E1..E64. At round=63, go to FINAL; the counter does not wrap inside ROUND.
- FINAL:
  - At edge E65: hash_out[i] = H_i + working_i (mod 2^32, per word).
  - done=1 for the following cycle; state returns to IDLE.
- Latency: done is high in the cycle after E65, i.e. 65 edges after start acceptance. Back-to-back throughput is one block per 66 cycles.
- start while busy is ignored and not queued. start held high continuously restarts on the cycle ready returns.
- block_in and hash_in are sampled only at E0 and may change freely afterwards.
- Functions:
  - Sigma0 = ROTR2^ROTR13^ROTR22; Sigma1 = ROTR6^ROTR11^ROTR25.
  - sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).

Optional Feature:
- Macro SHA256_CHAIN_EN.
- Defined: adds input port chain (1 bit).
  - chain=1 at start acceptance uses the current hash_out as the input state instead of hash_in.
  - chain=1 with hash_out still at reset value 0 uses 0; no IV substitution.
  - chain=0 behaves exactly as without the macro.
- Undefined: chain port absent; the input state always comes from hash_in.

Decomposition:
- Package sha256_pkg:
  - state enum (IDLE, ROUND, FINAL);
  - IV constants H0..H7 (6a09e667 ... 5be0cd19) for bench and front-end use;
  - rotation/shift amount constants;
  - pure functions Sigma0, Sigma1, sigma0, sigma1, ch, maj.
- Sub-module sha256_msg_schedule: 16x32 shift window with load, shift-enable, head output W_t and next-word generator.

Test Plan:
- "abc" block (61626380, 14 zero words, 00000018), hash_in=IV -> done after 65 edges; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (80000000, 15 zero words), hash_in=IV -> hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdef...nopq": feed block 2 with hash_in = block-1 digest (chain=1 when SHA256_CHAIN_EN is defined) -> hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Monitor k_index during one block -> exactly 0,1,...,63 on consecutive cycles while busy, 0 otherwise; ready low for exactly 65 cycles.
- Pulse start at round 20 with a different block -> ignored; digest equals the first block's; done pulses exactly once.
- Assert rst_n=0 at round 30, release, restart with "abc" -> outputs 0 during reset, then the correct "abc" digest; no spurious done.

Source files
------------

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared types, constants and round functions for the SHA-256 round engine.
//   state_t          : engine FSM states (IDLE, ROUND, FINAL)
//   IV_H0..IV_H7, IV : standard initial hash values (front end / bench use)
//   *_R*, *_S*       : rotation and shift amounts of the sigma functions
//   Sigma0/Sigma1    : compression-round functions on a and e
//   sigma0/sigma1    : message-schedule functions
//   ch/maj           : choose and majority
// -----------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] IV_H0 = 32'h6a09e667;
    localparam logic [31:0] IV_H1 = 32'hbb67ae85;
    localparam logic [31:0] IV_H2 = 32'h3c6ef372;
    localparam logic [31:0] IV_H3 = 32'ha54ff53a;
    localparam logic [31:0] IV_H4 = 32'h510e527f;
    localparam logic [31:0] IV_H5 = 32'h9b05688c;
    localparam logic [31:0] IV_H6 = 32'h1f83d9ab;
    localparam logic [31:0] IV_H7 = 32'h5be0cd19;
    localparam logic [255:0] IV = {IV_H0, IV_H1, IV_H2, IV_H3,
                                   IV_H4, IV_H5, IV_H6, IV_H7};

    localparam int unsigned BS0_R1 = 2;
    localparam int unsigned BS0_R2 = 13;
    localparam int unsigned BS0_R3 = 22;
    localparam int unsigned BS1_R1 = 6;
    localparam int unsigned BS1_R2 = 11;
    localparam int unsigned BS1_R3 = 25;
    localparam int unsigned SS0_R1 = 7;
    localparam int unsigned SS0_R2 = 18;
    localparam int unsigned SS0_S  = 3;
    localparam int unsigned SS1_R1 = 17;
    localparam int unsigned SS1_R2 = 19;
    localparam int unsigned SS1_S  = 10;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, BS0_R1) ^ rotr(x, BS0_R2) ^ rotr(x, BS0_R3);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, BS1_R1) ^ rotr(x, BS1_R2) ^ rotr(x, BS1_R3);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, SS0_R1) ^ rotr(x, SS0_R2) ^ (x >> SS0_S);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, SS1_R1) ^ rotr(x, SS1_R2) ^ (x >> SS1_S);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// -----------------------------------------------------------------------------
// sha256_round_engine_if
// Block request / digest bus between the padding front end (master) and the
// round engine (slave).
//   start    : request, sampled only while ready=1
//   block_in : 512-bit padded block, W0 in [511:480]
//   hash_in  : 256-bit input state, H0 in [255:224]
//   chain    : (only with SHA256_CHAIN_EN) use current hash_out as input state
//   ready    : engine idle
//   busy     : engine computing
//   done     : one-cycle pulse when hash_out updates
//   hash_out : 256-bit digest, held until the next done
// -----------------------------------------------------------------------------
interface sha256_round_engine_if;

    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
`ifdef SHA256_CHAIN_EN
    logic         chain;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

`ifdef SHA256_CHAIN_EN
    modport master (output start, block_in, hash_in, chain,
                    input  ready, busy, done, hash_out);
    modport slave  (input  start, block_in, hash_in, chain,
                    output ready, busy, done, hash_out);
`else
    modport master (output start, block_in, hash_in,
                    input  ready, busy, done, hash_out);
    modport slave  (input  start, block_in, hash_in,
                    output ready, busy, done, hash_out);
`endif

endinterface

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
// 16-word sliding message window. Word 0 is the head (W_t); each shift drops
// the head and appends W_{t+16} at the tail.
//   clk, rst_n : clock, async active-low reset (window cleared)
//   load       : load all 16 words from block_in (W0 = [511:480])
//   shift      : advance the window by one word
//   block_in   : padded 512-bit block
//   w_t        : current head word
// -----------------------------------------------------------------------------
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  w_t
);

    logic [31:0] win [16];
    logic [31:0] w_next;

    // Relative to the head at t: win[14]=W_{t+14}, win[9]=W_{t+9}, win[1]=W_{t+1}
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign w_t    = win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
        end else if (shift) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
        end
    end

endmodule

// File: rtl/sha256_round_engine.sv
// -----------------------------------------------------------------------------
// sha256_round_engine
// One SHA-256 compression per accepted block, one round per clock. The round
// constant is fetched from an external combinational table via k_index/k_in.
//   clk, rst_n : clock, async active-low reset (aborts any block in flight)
//   bus        : sha256_round_engine_if.slave (start/block/state in, digest out)
//   k_index    : round constant index (round number in ROUND, else 0)
//   k_in       : K[k_index], returned in the same cycle
// Optional build macro SHA256_CHAIN_EN adds bus.chain: when set at start
// acceptance, the current hash_out replaces hash_in as the input state.
//
// state | meaning
// IDLE  | ready; start latches state, a..h and the message window
// ROUND | round t = round counter, a..h updated every edge, 64 rounds
// FINAL | add working vars into H, pulse done, back to IDLE
// -----------------------------------------------------------------------------
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,  // fixed by the algorithm
    parameter int IDX_W      = 6    // 2**IDX_W must cover NUM_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_engine_if.slave bus,
    output logic [IDX_W-1:0]     k_index,
    input  logic [31:0]          k_in
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] round;
    logic [31:0]      hv [8];   // latched input state H0..H7
    logic [31:0]      wv [8];   // working vars, wv[0]=a .. wv[7]=h
    logic [31:0]      w_t;
    logic [31:0]      t1;
    logic [31:0]      t2;
    logic [255:0]     init_state;
    logic             accept;
    logic             last_round;

    assign accept     = (state == IDLE) && bus.start;
    assign last_round = (round == IDX_W'(NUM_ROUNDS - 1));

`ifdef SHA256_CHAIN_EN
    // No IV substitution: chaining straight after reset uses the all-zero state.
    assign init_state = bus.chain ? bus.hash_out : bus.hash_in;
`else
    assign init_state = bus.hash_in;
`endif

    sha256_msg_schedule u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift    (state == ROUND),
        .block_in (bus.block_in),
        .w_t      (w_t)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ROUND;
            ROUND:   if (last_round) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        k_index   = '0;
        case (state)
            IDLE:  bus.ready = 1'b1;
            ROUND: begin
                bus.busy = 1'b1;
                k_index  = round;
            end
            FINAL: bus.busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        t1 = wv[7] + Sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_in + w_t;
        t2 = Sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round        <= '0;
            bus.hash_out <= '0;
            bus.done     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= '0;
                wv[i] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        round <= '0;
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= init_state[255-32*i -: 32];
                            wv[i] <= init_state[255-32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    // hold at the last round; FINAL clears it
                    if (!last_round) round <= round + 1'b1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++)
                        bus.hash_out[255-32*i -: 32] <= hv[i] + wv[i];
                    bus.done <= 1'b1;
                    round    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
